// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and state type for the write-back stage
package wb_pkg;

  localparam logic [1:0] FONTE_ALU  = 2'b00;
  localparam logic [1:0] FONTE_MEM  = 2'b01;
  localparam logic [1:0] FONTE_PC4  = 2'b10;
  localparam logic [1:0] FONTE_IMED = 2'b11;

  localparam logic [2:0] CARGA_WORD   = 3'd0;
  localparam logic [2:0] CARGA_BYTE_S = 3'd1;
  localparam logic [2:0] CARGA_BYTE_U = 3'd2;
  localparam logic [2:0] CARGA_HALF_S = 3'd3;
  localparam logic [2:0] CARGA_HALF_U = 3'd4;

  typedef enum logic {OCIOSO, ESPERA} estado_t;

endpackage

// File: rtl/extensor_carga.sv
// rtl/extensor_carga.sv - sub-word load lane select, sign/zero extension and alignment check
module extensor_carga
  import wb_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic [LARGURA-1:0]         dadoLido,
  input  logic [2:0]                 tipo_carga,
  input  logic [$clog2(LARGURA/8)-1:0] deslocamento,
  output logic [LARGURA-1:0]         valorCarga,
  output logic                       desalinhado
);

  logic [LARGURA-1:0] deslocado;

  // Shifting instead of indexed part-select keeps misaligned halves in range.
  always_comb begin
    deslocado   = dadoLido >> {deslocamento, 3'b000};
    valorCarga  = deslocado;
    desalinhado = 1'b0;
    case (tipo_carga)
      CARGA_BYTE_S: valorCarga = {{(LARGURA-8){deslocado[7]}}, deslocado[7:0]};
      CARGA_BYTE_U: valorCarga = {{(LARGURA-8){1'b0}}, deslocado[7:0]};
      CARGA_HALF_S: begin
        valorCarga  = {{(LARGURA-16){deslocado[15]}}, deslocado[15:0]};
        desalinhado = deslocamento[0];
      end
      CARGA_HALF_U: begin
        valorCarga  = {{(LARGURA-16){1'b0}}, deslocado[15:0]};
        desalinhado = deslocamento[0];
      end
      default: desalinhado = (deslocamento != '0);
    endcase
  end

endmodule

// File: rtl/estagio_wb.sv
// rtl/estagio_wb.sv - registered MEM/WB stage with memory-ready wait and timeout
// Optional WB_CONTADORES_EN adds retired-instruction and stall-cycle counters.
module estagio_wb
  import wb_pkg::*;
#(
  parameter int LARGURA  = 32,
  parameter int BITS_REG = 5,
  parameter int TIMEOUT  = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valido_in,
  input  logic [1:0]                   fonte_wb,
  input  logic [2:0]                   tipo_carga,
  input  logic [$clog2(LARGURA/8)-1:0] deslocamento,
  input  logic [LARGURA-1:0]           resultadoALU,
  input  logic [LARGURA-1:0]           dadoLido,
  input  logic [LARGURA-1:0]           pc_mais4,
  input  logic [LARGURA-1:0]           imediato,
  input  logic                         memoria_pronta,
  input  logic [BITS_REG-1:0]          reg_destino,
  input  logic                         escreve_reg,
  input  logic                         flush,
  output logic [LARGURA-1:0]           resposta,
  output logic [BITS_REG-1:0]          reg_destino_out,
  output logic                         escreve_reg_out,
  output logic                         parado,
  output logic                         erro_mem,
  output logic                         erro_alinhamento
`ifdef WB_CONTADORES_EN
  ,
  output logic [31:0]                  instrucoes_retiradas,
  output logic [31:0]                  ciclos_parados
`endif
);

  localparam int BITS_CONT = $clog2(TIMEOUT + 1);

  estado_t              estado, proxEstado;
  logic [BITS_CONT-1:0] contador, proxContador;
  logic                 captura, estouro;
  logic [LARGURA-1:0]   valorCarga, valorSel;
  logic                 desalinhado, erroAlinh, retira;

  extensor_carga #(.LARGURA(LARGURA)) uExtensor (
    .dadoLido     (dadoLido),
    .tipo_carga   (tipo_carga),
    .deslocamento (deslocamento),
    .valorCarga   (valorCarga),
    .desalinhado  (desalinhado)
  );

  always_comb begin
    proxEstado   = estado;
    proxContador = contador;
    captura      = 1'b0;
    estouro      = 1'b0;
    parado       = 1'b0;
    if (flush) begin
      proxEstado   = OCIOSO;
      proxContador = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido_in) begin
            if (fonte_wb != FONTE_MEM || memoria_pronta) begin
              captura = 1'b1;
            end else begin
              parado       = 1'b1;
              proxEstado   = ESPERA;
              proxContador = '0;
            end
          end
        end
        ESPERA: begin
          if (memoria_pronta) begin
            captura    = 1'b1;
            proxEstado = OCIOSO;
          end else if (contador == BITS_CONT'(TIMEOUT)) begin
            // Give up: release the pipeline and drop the load.
            estouro      = 1'b1;
            proxEstado   = OCIOSO;
            proxContador = '0;
          end else begin
            parado       = 1'b1;
            proxContador = contador + 1'b1;
          end
        end
        default: proxEstado = OCIOSO;
      endcase
    end
  end

  always_comb begin
    case (fonte_wb)
      FONTE_ALU: valorSel = resultadoALU;
      FONTE_MEM: valorSel = valorCarga;
      FONTE_PC4: valorSel = pc_mais4;
      default:   valorSel = imediato;
    endcase
  end

  assign erroAlinh = (fonte_wb == FONTE_MEM) && desalinhado;
  assign retira    = captura && escreve_reg && !erroAlinh;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado           <= OCIOSO;
      contador         <= '0;
      resposta         <= '0;
      reg_destino_out  <= '0;
      escreve_reg_out  <= 1'b0;
      erro_mem         <= 1'b0;
      erro_alinhamento <= 1'b0;
    end else begin
      estado           <= proxEstado;
      contador         <= proxContador;
      escreve_reg_out  <= retira;
      erro_mem         <= estouro;
      erro_alinhamento <= captura && erroAlinh;
      if (captura) begin
        resposta        <= valorSel;
        reg_destino_out <= reg_destino;
      end
    end
  end

`ifdef WB_CONTADORES_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      instrucoes_retiradas <= '0;
      ciclos_parados       <= '0;
    end else begin
      if (retira) instrucoes_retiradas <= instrucoes_retiradas + 32'd1;
      if (parado) ciclos_parados <= ciclos_parados + 32'd1;
    end
  end
`endif

endmodule
